// File: rtl/pool_wb_sink.sv
// Writeback sink for pooled results: buffers controller strobes in a show-ahead FIFO,
// drains them to the memory write port and signals when a whole frame has left the FIFO.
module pool_wb_sink #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wrb,
  input  logic [ADDR_W-1:0]        wrb_addr,
  input  logic [DATA_W-1:0]        wrb_data,
  output logic                     wrb_stall,
  output logic                     mem_wr_valid,
  input  logic                     mem_wr_ready,
  output logic [ADDR_W-1:0]        mem_wr_addr,
  output logic [DATA_W-1:0]        mem_wr_data,
  output logic                     frame_done,
  output logic                     overflow,
  input  logic                     clr_err,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;
  localparam int unsigned CNT_W  = $clog2(FRAME_LEN + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [1:0]        state_q, state_d;
  logic              overflow_q, overflow_d;
  logic              stall_q, stall_d;

  logic pop, push, drop, room, open_state;

  assign mem_wr_valid = (fill_q != '0);
  assign pop          = mem_wr_valid && mem_wr_ready;
  assign open_state   = (state_q == IDLE) || (state_q == ACTIVE);
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign room         = (fill_q != FILL_W'(DEPTH)) || pop;
  assign push         = wrb && open_state && room;
  assign drop         = wrb && !push;

  // Head is gated so the port reads zero whenever nothing is buffered.
  assign mem_wr_addr = mem_wr_valid ? addr_mem[rd_ptr_q] : '0;
  assign mem_wr_data = mem_wr_valid ? data_mem[rd_ptr_q] : '0;

  assign fill       = fill_q;
  assign wrb_stall  = stall_q;
  assign overflow   = overflow_q;
  assign frame_done = (state_q == DONE);

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    fill_d   = fill_q;
    if (push && !pop) begin
      fill_d = fill_q + FILL_W'(1);
    end else if (pop && !push) begin
      fill_d = fill_q - FILL_W'(1);
    end
    stall_d = ((DEPTH - 32'(fill_d)) <= AF_MARGIN);
  end

  always_comb begin
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    if (state_q == DONE) begin
      in_cnt_d  = '0;
      out_cnt_d = '0;
    end else begin
      if (push) in_cnt_d  = in_cnt_q + CNT_W'(1);
      if (pop)  out_cnt_d = out_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (push) state_d = ACTIVE;
      ACTIVE:  if (push && (in_cnt_d == CNT_W'(FRAME_LEN))) state_d = FLUSH;
      FLUSH:   if (pop && (out_cnt_d == CNT_W'(FRAME_LEN))) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A drop in the same cycle as clr_err keeps the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_err) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= wrb_addr;
      data_mem[wr_ptr_q] <= wrb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      state_q    <= IDLE;
      overflow_q <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
      stall_q    <= stall_d;
    end
  end

endmodule

// File: tb/tb_pool_wb_sink.sv
// Directed bench for pool_wb_sink: a default-frame instance for FIFO behaviour and a
// FRAME_LEN=4 instance for frame sequencing.
module tb_pool_wb_sink;

  logic        clk;
  logic        reset;

  logic        a_wrb, a_ready, a_clr;
  logic [15:0] a_addr_in, a_data_in;
  logic        a_stall, a_valid, a_done, a_ovf;
  logic [15:0] a_addr, a_data;
  logic [3:0]  a_fill;

  logic        b_wrb, b_ready, b_clr;
  logic [15:0] b_addr_in, b_data_in;
  logic        b_stall, b_valid, b_done, b_ovf;
  logic [15:0] b_addr, b_data;
  logic [3:0]  b_fill;

  int total;
  int bad;

  pool_wb_sink dut (
    .clk          (clk),
    .reset        (reset),
    .wrb          (a_wrb),
    .wrb_addr     (a_addr_in),
    .wrb_data     (a_data_in),
    .wrb_stall    (a_stall),
    .mem_wr_valid (a_valid),
    .mem_wr_ready (a_ready),
    .mem_wr_addr  (a_addr),
    .mem_wr_data  (a_data),
    .frame_done   (a_done),
    .overflow     (a_ovf),
    .clr_err      (a_clr),
    .fill         (a_fill)
  );

  pool_wb_sink #(.FRAME_LEN(4)) dut4 (
    .clk          (clk),
    .reset        (reset),
    .wrb          (b_wrb),
    .wrb_addr     (b_addr_in),
    .wrb_data     (b_data_in),
    .wrb_stall    (b_stall),
    .mem_wr_valid (b_valid),
    .mem_wr_ready (b_ready),
    .mem_wr_addr  (b_addr),
    .mem_wr_data  (b_data),
    .frame_done   (b_done),
    .overflow     (b_ovf),
    .clr_err      (b_clr),
    .fill         (b_fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", a_valid); end
    total++; if (a_addr !== 16'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0000", a_addr); end
    total++; if (a_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0000", a_data); end
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", a_stall); end
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", a_done); end
    total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", a_ovf); end
    total++; if (a_fill !== 4'd0) begin bad++; $display("FAIL reset_fill got=%0d exp=0", a_fill); end
    total++; if (b_valid !== 1'b0 || b_fill !== 4'd0 || b_done !== 1'b0) begin
      bad++; $display("FAIL reset_dut4 got valid=%b fill=%0d done=%b exp 0/0/0", b_valid, b_fill, b_done);
    end
  endtask

  task automatic test_single();
    a_ready = 1'b1; a_wrb = 1'b1; a_addr_in = 16'h0010; a_data_in = 16'h1234;
    step();
    a_wrb = 1'b0;
    total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", a_valid); end
    total++; if (a_addr !== 16'h0010) begin bad++; $display("FAIL single_addr got=%h exp=0010", a_addr); end
    total++; if (a_data !== 16'h1234) begin bad++; $display("FAIL single_data got=%h exp=1234", a_data); end
    total++; if (a_fill !== 4'd1) begin bad++; $display("FAIL single_fill1 got=%0d exp=1", a_fill); end
    step();
    total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%b exp=0", a_valid); end
    total++; if (a_fill !== 4'd0) begin bad++; $display("FAIL single_fill0 got=%0d exp=0", a_fill); end
  endtask

  task automatic test_fill_stall();
    a_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_wrb = 1'b1; a_addr_in = 16'h0100 + 16'(i); a_data_in = 16'hA000 + 16'(i);
      step();
      total++; if (a_fill !== 4'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, a_fill, i + 1); end
      total++; if (a_stall !== (i >= 5)) begin bad++; $display("FAIL stall[%0d] got=%b exp=%b", i, a_stall, (i >= 5)); end
    end
    a_addr_in = 16'h01FF; a_data_in = 16'hDEAD;
    step();
    a_wrb = 1'b0;
    total++; if (a_ovf !== 1'b1) begin bad++; $display("FAIL ninth_ovf got=%b exp=1", a_ovf); end
    total++; if (a_fill !== 4'd8) begin bad++; $display("FAIL ninth_fill got=%0d exp=8", a_fill); end
    total++; if (a_addr !== 16'h0100) begin bad++; $display("FAIL full_head got=%h exp=0100", a_addr); end
  endtask

  task automatic test_clr_err();
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL clr_err got=%b exp=0", a_ovf); end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] ea, ed;
    a_wrb = 1'b1; a_addr_in = 16'h0200; a_data_in = 16'hB000; a_ready = 1'b1;
    step();
    a_wrb = 1'b0; a_ready = 1'b0;
    total++; if (a_fill !== 4'd8) begin bad++; $display("FAIL pushpop_fill got=%0d exp=8", a_fill); end
    total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL pushpop_ovf got=%b exp=0", a_ovf); end
    total++; if (a_stall !== 1'b1) begin bad++; $display("FAIL pushpop_stall got=%b exp=1", a_stall); end
    total++; if (a_addr !== 16'h0101) begin bad++; $display("FAIL pushpop_head got=%h exp=0101", a_addr); end
    a_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ea = (k < 7) ? 16'h0101 + 16'(k) : 16'h0200;
      ed = (k < 7) ? 16'hA001 + 16'(k) : 16'hB000;
      total++; if (a_valid !== 1'b1 || a_addr !== ea || a_data !== ed) begin
        bad++; $display("FAIL drain[%0d] got v=%b %h/%h exp v=1 %h/%h", k, a_valid, a_addr, a_data, ea, ed);
      end
      step();
    end
    total++; if (a_valid !== 1'b0 || a_fill !== 4'd0) begin
      bad++; $display("FAIL drain_empty got v=%b fill=%0d exp v=0 fill=0", a_valid, a_fill);
    end
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL drain_stall got=%b exp=0", a_stall); end
  endtask

  task automatic test_frame();
    int dones;
    b_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_wrb = 1'b1; b_addr_in = 16'h0300 + 16'(i); b_data_in = 16'hC000 + 16'(i);
      step();
      total++; if (b_done !== 1'b0) begin bad++; $display("FAIL frame_early_done[%0d] got=%b exp=0", i, b_done); end
    end
    total++; if (b_fill !== 4'd1 || b_addr !== 16'h0303) begin
      bad++; $display("FAIL frame_last_head got fill=%0d addr=%h exp fill=1 addr=0303", b_fill, b_addr);
    end
    // Fifth strobe lands in FLUSH together with clr_err: the drop must win.
    b_wrb = 1'b1; b_clr = 1'b1; b_addr_in = 16'h03FF;
    step();
    b_wrb = 1'b0; b_clr = 1'b0;
    total++; if (b_done !== 1'b1) begin bad++; $display("FAIL frame_done_pulse got=%b exp=1", b_done); end
    total++; if (b_ovf !== 1'b1) begin bad++; $display("FAIL flush_drop_ovf got=%b exp=1", b_ovf); end
    total++; if (b_fill !== 4'd0) begin bad++; $display("FAIL flush_fill got=%0d exp=0", b_fill); end
    b_clr = 1'b1;
    step();
    b_clr = 1'b0;
    total++; if (b_done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b exp=0", b_done); end
    total++; if (b_ovf !== 1'b0) begin bad++; $display("FAIL frame_clr got=%b exp=0", b_ovf); end
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      b_wrb = 1'b1; b_addr_in = 16'h0400 + 16'(i); b_data_in = 16'hD000 + 16'(i);
      step();
      if (b_done === 1'b1) dones++;
      if (i == 0) begin
        total++; if (b_fill !== 4'd1) begin bad++; $display("FAIL frame2_accept got=%0d exp=1", b_fill); end
      end
    end
    b_wrb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (b_done === 1'b1) dones++;
    end
    total++; if (dones != 1) begin bad++; $display("FAIL frame2_done_count got=%0d exp=1", dones); end
    total++; if (b_ovf !== 1'b0) begin bad++; $display("FAIL frame2_ovf got=%b exp=0", b_ovf); end
  endtask

  task automatic test_async_reset();
    int dones;
    a_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_wrb = 1'b1; a_addr_in = 16'h0500 + 16'(i); a_data_in = 16'hE000 + 16'(i);
      step();
    end
    a_wrb = 1'b0;
    total++; if (a_fill !== 4'd5) begin bad++; $display("FAIL pre_reset_fill got=%0d exp=5", a_fill); end
    #2 reset = 1'b0;
    #1;
    total++; if (a_valid !== 1'b0 || a_fill !== 4'd0 || a_addr !== 16'h0 || a_data !== 16'h0) begin
      bad++; $display("FAIL async_reset got v=%b fill=%0d %h/%h exp 0", a_valid, a_fill, a_addr, a_data);
    end
    total++; if (a_stall !== 1'b0 || a_ovf !== 1'b0 || a_done !== 1'b0) begin
      bad++; $display("FAIL async_reset_flags got st=%b ovf=%b done=%b exp 0", a_stall, a_ovf, a_done);
    end
    #3 reset = 1'b1;
    a_ready = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (a_done === 1'b1 || a_valid === 1'b1) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL post_reset_activity got=%0d exp=0", dones); end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b0;
    a_wrb = 1'b0; a_ready = 1'b0; a_clr = 1'b0; a_addr_in = '0; a_data_in = '0;
    b_wrb = 1'b0; b_ready = 1'b1; b_clr = 1'b0; b_addr_in = '0; b_data_in = '0;
    #12 reset = 1'b1;
    step();
    test_reset();
    test_single();
    test_fill_stall();
    test_clr_err();
    test_full_push_pop();
    test_frame();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pool_wb_sink.md
Name: pool_wb_sink

Overview:
Receiving end of the pooling writeback interface driven by Main_controller (wrb strobe + wrb_addr + pooled data word).
- Each accepted word is buffered in a small show-ahead FIFO.
- Buffered words drain to the DRAM/output-SRAM write port over a valid/ready handshake.
- Words accepted per frame are counted, and a frame_done pulse fires once the last word of the frame has drained.
- Dropped strobes are flagged sticky; almost-full back-pressure is offered to the controller.

Parameters:
ADDR_W, 16, width of wrb_addr / mem_wr_addr (matches FULL_ADDR)
DATA_W, 16, pooled data word width
DEPTH, 8, FIFO entries; power of two, >= 4
FRAME_LEN, 1024, words per output frame; >= 2
AF_MARGIN, 2, wrb_stall asserts when free entries <= AF_MARGIN

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous reset, active-low (asserted at 0)
wrb  in  1  one-cycle writeback strobe from controller
wrb_addr  in  ADDR_W  destination address, valid with wrb
wrb_data  in  DATA_W  pooled word, valid with wrb
wrb_stall  out  1  almost-full back-pressure to controller
mem_wr_valid  out  1  head entry valid toward memory
mem_wr_ready  in  1  memory accepts head entry
mem_wr_addr  out  ADDR_W  head entry address
mem_wr_data  out  DATA_W  head entry data
frame_done  out  1  one-cycle pulse: last word of frame has drained
overflow  out  1  sticky: a wrb strobe was dropped
clr_err  in  1  synchronous clear of overflow
fill  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset=0, async): FIFO empty; pointers 0; frame counters 0; state IDLE.
  - Outputs: mem_wr_valid=0, mem_wr_addr=0, mem_wr_data=0, wrb_stall=0, frame_done=0, overflow=0, fill=0.
  - Reset mid-frame discards all buffered words; no frame_done is issued.
- Pop: occurs when mem_wr_valid && mem_wr_ready.
  - mem_wr_valid = (fill != 0).
  - Addr/data are the head entry and hold stable while valid && !ready.
- Push: occurs when wrb=1 and the strobe is accepted (see state rules).
  - An accepted strobe requires fill < DEPTH, or a pop in the same cycle. Full + push + pop → both happen; fill unchanged.
  - Latency: wrb at edge N into an empty FIFO → mem_wr_valid=1 with that word after edge N (visible cycle N+1).
  - No same-cycle bypass.
- fill: updated +1 / -1 / 0 per edge, registered.
- wrb_stall: registered, equals (DEPTH - fill_next) <= AF_MARGIN. It is advisory only; strobes still arrive while it is asserted.
- Dropped strobe: wrb=1 that is not accepted sets overflow=1. The word is discarded and not counted.
  - overflow clears only on clr_err=1 or reset.
  - clr_err and a new drop in the same cycle → overflow=1 (set wins).
- Counters:
  - in_cnt counts accepted pushes in the frame, 0..FRAME_LEN.
  - out_cnt counts pops in the frame, 0..FRAME_LEN.
- State machine:
  - IDLE: in_cnt=0. First accepted push → ACTIVE.
  - ACTIVE: accepts pushes. The push making in_cnt==FRAME_LEN → FLUSH.
  - FLUSH: every wrb is dropped (overflow=1) and pops continue. The pop making out_cnt==FRAME_LEN → DONE.
  - DONE: one cycle; frame_done=1; counters clear to 0; wrb is dropped this cycle; → IDLE.
- Address handling: no ordering or range checks; addresses are forwarded unmodified.
- ADDR_W/DATA_W arithmetic: none. Counters are sized $clog2(FRAME_LEN+1) and never wrap within a frame.

Test Plan:
1. Reset, then wrb=1 for one cycle with addr=0x0010, data=0x1234, mem_wr_ready=1 → mem_wr_valid=1 the next cycle with 0x0010/0x1234, popped that cycle; fill 0→1→0.
2. mem_wr_ready=0, 8 back-to-back strobes (DEPTH=8) → fill=8; wrb_stall=1 once fill>=6. A 9th strobe → overflow=1; the first 8 words drain in order after ready=1.
3. Full FIFO, wrb=1 and ready=1 in the same cycle → push accepted, fill stays 8, overflow stays 0.
4. FRAME_LEN=4: 4 strobes, ready=1 → frame_done pulses exactly once, the cycle after the 4th pop. A 5th strobe during FLUSH → overflow=1. The next frame starts from in_cnt=0.
5. Assert reset=0 asynchronously with fill=5 mid-frame → all outputs go to 0 immediately; no frame_done after release.
6. overflow=1, clr_err=1 with no drop → overflow=0 next edge; clr_err coincident with a drop → overflow remains 1.
